// File: rtl/cordic_pkg.sv
// Shared constants, state type and table helper for the CORDIC sine/cosine units.
package cordic_pkg;

  localparam int CNT_W = 5;

  localparam logic signed [31:0] INV_K_Q30 = 32'sh26DD3B6A;

  localparam logic signed [31:0] ATAN_Q30 [0:31] = '{
    32'sh3243F6A8, 32'sh1DAC6705, 32'sh0FADBAFC, 32'sh07F56EA6,
    32'sh03FEAB76, 32'sh01FFD55B, 32'sh00FFFAAA, 32'sh007FFF55,
    32'sh003FFFEA, 32'sh001FFFFD, 32'sh000FFFFF, 32'sh0007FFFF,
    32'sh0003FFFF, 32'sh0001FFFF, 32'sh0000FFFF, 32'sh00007FFF,
    32'sh00003FFF, 32'sh00001FFF, 32'sh00000FFF, 32'sh000007FF,
    32'sh000003FF, 32'sh000001FF, 32'sh000000FF, 32'sh0000007F,
    32'sh0000003F, 32'sh0000001F, 32'sh0000000F, 32'sh00000008,
    32'sh00000004, 32'sh00000002, 32'sh00000001, 32'sh00000000
  };

  typedef enum logic [1:0] {IDLE, RUN, DONE} cordic_state_t;

  // Narrow a Q2.30 table entry to Q2.(w-2); the half-LSB offset keeps the
  // per-entry error centred so it does not accumulate over the iterations.
  function automatic logic signed [31:0] atan_scaled(input logic [CNT_W-1:0] idx,
                                                     input int w);
    logic signed [31:0] half;
    half = 32'sd1 <<< (31 - w);
    return (ATAN_Q30[idx] + half) >>> (32 - w);
  endfunction

endpackage

// File: rtl/cordic_iter_stage.sv
// One combinational rotation-mode CORDIC micro-rotation; shared with the pipelined variant.
module cordic_iter_stage
  import cordic_pkg::*;
#(
  parameter int XW = 24,
  parameter int ZW = 22
) (
  input  logic signed [XW-1:0] x_i,
  input  logic signed [XW-1:0] y_i,
  input  logic signed [ZW-1:0] z_i,
  input  logic [CNT_W-1:0]     i_i,
  input  logic signed [ZW-1:0] atan_i,
  output logic signed [XW-1:0] x_o,
  output logic signed [XW-1:0] y_o,
  output logic signed [ZW-1:0] z_o
);

  logic signed [XW-1:0] x_sh;
  logic signed [XW-1:0] y_sh;

  assign x_sh = x_i >>> i_i;
  assign y_sh = y_i >>> i_i;

  // Rotate towards z = 0: positive residual angle means a positive rotation.
  always_comb begin
    if (!z_i[ZW-1]) begin
      x_o = x_i - y_sh;
      y_o = y_i + x_sh;
      z_o = z_i - atan_i;
    end else begin
      x_o = x_i + y_sh;
      y_o = y_i - x_sh;
      z_o = z_i + atan_i;
    end
  end

endmodule

// File: rtl/cordic_sincos_mc.sv
// Multi-cycle rotation-mode CORDIC: sin or cos of a Q2.(WIDTH-2) angle over a start/done handshake.
// Define CORDIC_GAIN_COMP_EN to start from 1/K so outputs are true sin/cos instead of K-scaled.
module cordic_sincos_mc
  import cordic_pkg::*;
#(
  parameter int WIDTH      = 22,
  parameter int ITERATIONS = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic        n,
  input  logic [31:0] dataa,
  output logic        done,
  output logic [31:0] result
);

  // x/y run in Q2.WIDTH: two guard LSBs beyond the output format.
  localparam int XW = WIDTH + 2;
`ifdef CORDIC_GAIN_COMP_EN
  localparam logic signed [31:0] X0_FULL = INV_K_Q30 >>> (30 - WIDTH);
`else
  localparam logic signed [31:0] X0_FULL = 32'sd1 <<< WIDTH;
`endif
  localparam logic signed [XW-1:0] X0 = X0_FULL[XW-1:0];

  cordic_state_t           state_q, state_d;
  logic [CNT_W-1:0]        i_q, i_d;
  logic signed [XW-1:0]    x_q, x_d, x_nx;
  logic signed [XW-1:0]    y_q, y_d, y_nx;
  logic signed [WIDTH-1:0] z_q, z_d, z_nx;
  logic signed [WIDTH-1:0] atan_w;
  logic signed [31:0]      atan_full;
  logic                    mode_q, mode_d;
  logic                    done_q, done_d;
  logic [31:0]             result_q, result_d;
  logic                    unused_bits;

  function automatic logic [31:0] to_result(input logic signed [XW-1:0] v);
    logic signed [WIDTH-1:0] t;
    t = WIDTH'(v >>> 2);
    return 32'(t);
  endfunction

  assign atan_full   = atan_scaled(i_q, WIDTH);
  assign atan_w      = atan_full[WIDTH-1:0];
  assign unused_bits = ^{dataa[31:WIDTH], atan_full[31:WIDTH]};

  cordic_iter_stage #(
    .XW (XW),
    .ZW (WIDTH)
  ) u_iter (
    .x_i    (x_q),
    .y_i    (y_q),
    .z_i    (z_q),
    .i_i    (i_q),
    .atan_i (atan_w),
    .x_o    (x_nx),
    .y_o    (y_nx),
    .z_o    (z_nx)
  );

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    mode_d   = mode_q;
    result_d = result_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = X0;
          y_d     = '0;
          z_d     = dataa[WIDTH-1:0];
          mode_d  = n;
          i_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        x_d = x_nx;
        y_d = y_nx;
        z_d = z_nx;
        i_d = i_q + 1'b1;
        if (i_q == CNT_W'(ITERATIONS - 1)) state_d = DONE;
      end
      DONE: begin
        result_d = to_result(mode_q ? y_q : x_q);
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      i_q      <= '0;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      mode_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else if (clk_en) begin
      state_q  <= state_d;
      i_q      <= i_d;
      x_q      <= x_d;
      y_q      <= y_d;
      z_q      <= z_d;
      mode_q   <= mode_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  // A stalled cycle must never present done to the processor.
  assign done   = done_q & clk_en;
  assign result = result_q;

endmodule

// File: tb/tb_cordic_sincos_mc.sv
// Scoreboard bench for cordic_sincos_mc: directed angles, handshake corner cases, random sweep.
module tb_cordic_sincos_mc;

  localparam int N       = 20;
  localparam int LAT     = N + 2;
  localparam int TOL     = 8;
  localparam int HALF_PI = 1647099;

  logic        clk = 1'b0;
  logic        reset, clk_en, start, n;
  logic [31:0] dataa;
  logic        done;
  logic [31:0] result;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    string tag;
    int    val;
    int    at;
  } exp_t;

  exp_t sb[$];

  cordic_sincos_mc #(
    .WIDTH      (22),
    .ITERATIONS (N)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .start  (start),
    .n      (n),
    .dataa  (dataa),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int want, input int tol);
    int d;
    n_chk++;
    d = obs - want;
    if (d < 0) d = -d;
    if (d > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%08h), want %0d +/-%0d", tag, obs, obs, want, tol);
    end
  endtask

  function automatic int model(input logic nn, input logic [21:0] ang);
    real th, v;
    th = real'($signed(ang)) / 1048576.0;
    v  = nn ? $sin(th) : $cos(th);
`ifndef CORDIC_GAIN_COMP_EN
    v = v * 1.646760258;
`endif
    return $rtoi($floor(v * 1048576.0 + 0.5));
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", int'(done), 0, 0);
      end else begin
        e = sb.pop_front();
        chk({e.tag, "_latency"}, cyc, e.at, 0);
        chk(e.tag, $signed(result), e.val, TOL);
      end
    end
  end

  task automatic issue(input logic nn, input logic [21:0] ang, input string tag,
                       input int frozen, input bit expect_done);
    @(negedge clk);
    start = 1'b1;
    n     = nn;
    dataa = {10'($urandom()), ang};
    if (expect_done) sb.push_back(exp_t'{tag, model(nn, ang), cyc + LAT + frozen});
    @(negedge clk);
    start = 1'b0;
    n     = ~nn;
    dataa = $urandom();
  endtask

  task automatic wait_drain(input string tag);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      chk({tag, "_timeout"}, sb.size(), 0, 0);
      sb.delete();
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: stuck at cycle %0d, %0d/%0d checks passed", cyc, n_chk - n_fail, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [21:0] ang;
    int          a;
    reset  = 1'b1;
    clk_en = 1'b1;
    start  = 1'b0;
    n      = 1'b0;
    dataa  = '0;
    repeat (2) @(negedge clk);
    chk("reset_result", $signed(result), 0, 0);
    chk("reset_done", int'(done), 0, 0);
    reset = 1'b0;

    issue(1'b0, 22'h000000, "zero_cos", 0, 1'b1);   wait_drain("zero_cos");
    issue(1'b1, 22'h000000, "zero_sin", 0, 1'b1);   wait_drain("zero_sin");
    issue(1'b0, 22'h0C90FE, "pi4_cos", 0, 1'b1);    wait_drain("pi4_cos");
    issue(1'b1, 22'h0C90FE, "pi4_sin", 0, 1'b1);    wait_drain("pi4_sin");
    issue(1'b1, 22'h26DE05, "mpi2_sin", 0, 1'b1);   wait_drain("mpi2_sin");
    issue(1'b0, 22'h26DE05, "mpi2_cos", 0, 1'b1);   wait_drain("mpi2_cos");

    // Extra start pulses mid-run must be ignored.
    issue(1'b0, 22'h0C90FE, "restart_ign", 0, 1'b1);
    repeat (2) @(negedge clk);
    start = 1'b1; n = 1'b1; dataa = 32'h0026DE05;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    start = 1'b1; n = 1'b1; dataa = 32'h00100000;
    @(negedge clk);
    start = 1'b0;
    wait_drain("restart_ign");

    // Five stalled cycles mid-run stretch the latency by five.
    issue(1'b1, 22'h0C90FE, "stall", 5, 1'b1);
    repeat (4) @(negedge clk);
    clk_en = 1'b0;
    repeat (5) @(negedge clk);
    clk_en = 1'b1;
    wait_drain("stall");

    // Asynchronous reset mid-run: result clears at once and no done follows.
    issue(1'b1, 22'h26DE05, "rst_run", 0, 1'b0);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_mid_result", $signed(result), 0, 0);
    chk("rst_mid_done", int'(done), 0, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("rst_after_result", $signed(result), 0, 0);

    issue(1'b0, 22'h0C90FE, "post_rst", 0, 1'b1);   wait_drain("post_rst");

    for (int k = 0; k < 1000; k++) begin
      a   = int'($urandom_range(2 * HALF_PI)) - HALF_PI;
      ang = 22'(a);
      issue(1'b0, ang, "rnd_cos", 0, 1'b1);  wait_drain("rnd_cos");
      issue(1'b1, ang, "rnd_sin", 0, 1'b1);  wait_drain("rnd_sin");
    end

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
